// File: rtl/addsub_pipe_mc.sv
// Pipelined multi-limb adder/subtractor: per-limb sums in S0, then a
// log-depth carry-merge tree, with a global-stall valid/ready handshake.
module addsub_pipe_mc #(
    parameter int WIDTH = 272,
    parameter int LIMBS = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LW = WIDTH / LIMBS;
    localparam int L  = 1 + $clog2(LIMBS);

    logic w_stall;
    logic w_adv;

    assign w_stall  = out_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    genvar k, j;
    generate
        for (k = 0; k < L; k++) begin : g_stg
            localparam int G = LIMBS >> k;

            logic [WIDTH-1:0] r_sum;
            logic [G-1:0]     r_cy;
            logic             r_vld;
            logic [TAG_W-1:0] r_tag;

            logic [WIDTH-1:0] w_sum;
            logic [G-1:0]     w_cy;
            logic             w_vld;
            logic [TAG_W-1:0] w_tag;

            if (k == 0) begin : g_lsum
                logic [WIDTH-1:0] w_yp;

                assign w_yp  = sub ? ~Y : Y;
                assign w_vld = in_valid & in_ready;
                assign w_tag = in_tag;

                for (j = 0; j < LIMBS; j++) begin : g_limb
                    logic w_cin;

                    // Only the lowest limb takes the +1 of two's-complement subtract.
                    assign w_cin = (j == 0) ? sub : 1'b0;
                    assign {w_cy[j], w_sum[j*LW +: LW]} =
                        {1'b0, X[j*LW +: LW]} +
                        {1'b0, w_yp[j*LW +: LW]} +
                        {{LW{1'b0}}, w_cin};
                end
            end else begin : g_merge
                localparam int GW = LW << (k - 1);

                assign w_vld = g_stg[k-1].r_vld;
                assign w_tag = g_stg[k-1].r_tag;

                for (j = 0; j < G; j++) begin : g_grp
                    logic [GW:0] w_hi;

                    // Upper groups carry no carry-in, so {cy,sum}+1 never exceeds GW+1 bits.
                    assign w_hi =
                        {g_stg[k-1].r_cy[2*j+1],
                         g_stg[k-1].r_sum[(2*j+1)*GW +: GW]} +
                        {{GW{1'b0}}, g_stg[k-1].r_cy[2*j]};
                    assign w_sum[2*j*GW +: GW] =
                        g_stg[k-1].r_sum[2*j*GW +: GW];
                    assign w_sum[(2*j+1)*GW +: GW] = w_hi[GW-1:0];
                    assign w_cy[j] = w_hi[GW];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum <= '0;
                    r_cy  <= '0;
                    r_vld <= 1'b0;
                    r_tag <= '0;
                end else if (w_adv) begin
                    r_sum <= w_sum;
                    r_cy  <= w_cy;
                    r_vld <= w_vld;
                    r_tag <= w_tag;
                end
            end
        end
    endgenerate

    assign Z         = g_stg[L-1].r_sum;
    assign carry     = g_stg[L-1].r_cy[0];
    assign out_tag   = g_stg[L-1].r_tag;
    assign out_valid = g_stg[L-1].r_vld;

endmodule

// File: tb/tb_addsub_pipe_mc.sv
// Bench for addsub_pipe_mc: directed vectors on the default build plus a
// random sweep over LIMBS=1/8/16, checked against an arithmetic scoreboard.
module tb_addsub_pipe_mc;

    localparam int N = 4;

    typedef struct packed {
        logic [271:0] z;
        logic         c;
        logic [3:0]   tag;
        int           rem;
    } ent_t;

    int wv [N] = '{272, 272, 256, 272};
    int lv [N] = '{3, 1, 4, 5};

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]        iv, ordy, sb, ir, ov, cy;
    logic [N-1:0][271:0] xv, yv, zz;
    logic [N-1:0][3:0]   it, ot;
    logic [271:0] z0, z1, z3;
    logic [255:0] z2;

    assign zz = {z3, {16'b0, z2}, z1, z0};

    always #5 clk = ~clk;

    addsub_pipe_mc #(.WIDTH(272), .LIMBS(4), .TAG_W(4)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .X(xv[0]), .Y(yv[0]), .sub(sb[0]), .in_tag(it[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .Z(z0),
        .carry(cy[0]), .out_tag(ot[0]));

    addsub_pipe_mc #(.WIDTH(272), .LIMBS(1), .TAG_W(4)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .X(xv[1]), .Y(yv[1]), .sub(sb[1]), .in_tag(it[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .Z(z1),
        .carry(cy[1]), .out_tag(ot[1]));

    addsub_pipe_mc #(.WIDTH(256), .LIMBS(8), .TAG_W(4)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .X(xv[2][255:0]), .Y(yv[2][255:0]), .sub(sb[2]), .in_tag(it[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .Z(z2),
        .carry(cy[2]), .out_tag(ot[2]));

    addsub_pipe_mc #(.WIDTH(272), .LIMBS(16), .TAG_W(4)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .X(xv[3]), .Y(yv[3]), .sub(sb[3]), .in_tag(it[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .Z(z3),
        .carry(cy[3]), .out_tag(ot[3]));

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    logic lrst;
    ent_t mq [N][64];
    int hd [N] = '{0, 0, 0, 0};
    int cnt [N] = '{0, 0, 0, 0};
    int acc [N] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input logic [272:0] act,
                       input logic [272:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Plain arithmetic reference: X+Y or X-Y mod 2^w, carry = overflow / no-borrow.
    function automatic ent_t golden(input logic [271:0] x, input logic [271:0] y,
                                    input logic s, input logic [3:0] t,
                                    input int w, input int lat);
        ent_t e;
        logic [272:0] m, xm, ym, r;
        m  = (273'(1) << w) - 273'(1);
        xm = {1'b0, x} & m;
        ym = {1'b0, y} & m;
        if (s) begin
            e.c = (xm >= ym);
            r   = (xm - ym) & m;
        end else begin
            r   = xm + ym;
            e.c = r[w];
            r   = r & m;
        end
        e.z   = r[271:0];
        e.tag = t;
        e.rem = lat - 1;
        return e;
    endfunction

    function automatic logic [271:0] rnd();
        logic [271:0] v;
        v = '0;
        case ($urandom_range(0, 5))
            0: v = '1;
            1: v = '0;
            2: begin v = '1; v = v >> $urandom_range(0, 271); end
            3: v = 272'(1) << $urandom_range(0, 271);
            default: for (int k = 0; k < 9; k++) v = {v[239:0], 32'($urandom)};
        endcase
        return v;
    endfunction

    always @(posedge clk) lrst <= rst;

    always @(negedge clk) begin
        logic ev, er;
        ent_t f;
        int idx;
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                ev = (cnt[i] > 0) && (mq[i][hd[i]].rem == 0);
                if (lrst) begin
                    chk($sformatf("rst_z%0d", i), zz[i], 0);
                    chk($sformatf("rst_c%0d", i), cy[i], 0);
                    chk($sformatf("rst_tag%0d", i), ot[i], 0);
                end
                chk($sformatf("out_valid%0d", i), ov[i], ev);
                if (ev && ov[i]) begin
                    f = mq[i][hd[i]];
                    chk($sformatf("z%0d", i), zz[i], f.z);
                    chk($sformatf("carry%0d", i), cy[i], f.c);
                    chk($sformatf("tag%0d", i), ot[i], f.tag);
                end
                er = !(ev && !ordy[i]);
                chk($sformatf("in_ready%0d", i), ir[i], er);
                if (rst) begin
                    cnt[i] = 0;
                    hd[i]  = 0;
                end else begin
                    if (ev && ordy[i]) begin
                        hd[i]  = (hd[i] + 1) % 64;
                        cnt[i] = cnt[i] - 1;
                    end
                    if (er) begin
                        for (int k = 0; k < cnt[i]; k++) begin
                            idx = (hd[i] + k) % 64;
                            if (mq[i][idx].rem > 0)
                                mq[i][idx].rem = mq[i][idx].rem - 1;
                        end
                    end
                    if (iv[i] && er) begin
                        idx = (hd[i] + cnt[i]) % 64;
                        mq[i][idx] = golden(xv[i], yv[i], sb[i], it[i], wv[i], lv[i]);
                        cnt[i] = cnt[i] + 1;
                        acc[i] = acc[i] + 1;
                    end
                end
            end
        end
    end

    task automatic op_chk(input string nm, input logic [271:0] x,
                          input logic [271:0] y, input logic s,
                          input logic [3:0] t, input logic [271:0] ez,
                          input logic ec);
        xv[0] = x; yv[0] = y; sb[0] = s; it[0] = t; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_early"}, ov[0], 0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, ov[0], 1);
        chk({nm, "_z"}, z0, ez);
        chk({nm, "_carry"}, cy[0], ec);
        chk({nm, "_tag"}, ot[0], t);
    endtask

    logic [271:0] ones, p68, p136, p200, hz;
    logic hc;
    logic [3:0] ht;
    logic [3:0] seen [16];
    int ns, first, last, nv, sent, rcv, win, cyc;
    bit started, acc0;

    initial begin
        ones = '1;
        p68  = 272'(1) << 68;
        p136 = 272'(1) << 136;
        p200 = 272'(1) << 200;
        rst = 1'b1;
        iv = '0; ordy = '1; sb = '0; xv = '0; yv = '0; it = '0;
        iv[0] = 1'b1; xv[0] = 272'd1; yv[0] = 272'd1; it[0] = 4'd9;

        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            cmp_en = 1'b1;
            chk("reset_valid", ov[0], 0);
            chk("reset_z", z0, 0);
            chk("reset_carry", cy[0], 0);
            chk("reset_tag", ot[0], 0);
        end
        rst = 1'b0;
        iv[0] = 1'b0;
        chk("ready_after_reset", ir[0], 1);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ov[0]) nv++;
        end
        chk("dropped_in_reset", nv, 0);

        op_chk("carry_full", ones, 272'd1, 1'b0, 4'd5, 272'd0, 1'b1);
        op_chk("carry_half", p136 - 272'd1, 272'd1, 1'b0, 4'd6, p136, 1'b0);
        op_chk("carry_limb", p68 - 272'd1, 272'd1, 1'b0, 4'd2, p68, 1'b0);
        op_chk("sub_borrow", 272'd0, 272'd1, 1'b1, 4'd7, ones, 1'b0);
        op_chk("sub_equal", 272'd5, 272'd5, 1'b1, 4'd8, 272'd0, 1'b1);
        op_chk("sub_p200", p200, 272'd1, 1'b1, 4'd9, p200 - 272'd1, 1'b1);

        ns = 0; first = -1; last = -1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                iv[0] = 1'b1;
                xv[0] = ones >> (c * 17);
                yv[0] = (272'(c) << (c * 30)) | 272'(c + 3);
                sb[0] = c[0];
                it[0] = 4'(c);
            end else begin
                iv[0] = 1'b0;
            end
            @(posedge clk); #1;
            if (ov[0]) begin
                if (ns < 16) seen[ns] = ot[0];
                ns++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("stream_count", ns, 8);
        chk("stream_contig", last - first, 7);
        for (int k = 0; k < 8; k++)
            chk($sformatf("stream_order%0d", k), seen[k], k);

        sent = 0; rcv = 0; win = 0; started = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!started && ov[0]) begin
                started = 1'b1;
                win = 4;
                hz = z0; hc = cy[0]; ht = ot[0];
            end
            ordy[0] = !(win > 0);
            iv[0] = (sent < 8);
            xv[0] = {17{16'(sent * 4099 + 1)}};
            yv[0] = ones >> (sent * 9);
            sb[0] = (sent % 3 == 1);
            it[0] = 4'(sent);
            #1;
            if (win > 0) begin
                chk("bp_ready_low", ir[0], 0);
                if (win < 4) begin
                    chk("bp_hold_z", z0, hz);
                    chk("bp_hold_carry", cy[0], hc);
                    chk("bp_hold_tag", ot[0], ht);
                end
            end
            acc0 = iv[0] && ir[0];
            if (ov[0] && ordy[0]) begin
                chk("bp_order", ot[0], rcv);
                rcv++;
            end
            @(posedge clk); #1;
            if (acc0) sent++;
            if (win > 0) win--;
        end
        chk("bp_sent", sent, 8);
        chk("bp_received", rcv, 8);
        ordy[0] = 1'b1;
        iv[0] = 1'b0;

        for (int c = 0; c < 2; c++) begin
            iv[0] = 1'b1;
            xv[0] = ones;
            yv[0] = 272'(c + 1);
            sb[0] = 1'b0;
            it[0] = 4'(c + 10);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        it[0] = 4'd12;
        @(posedge clk); #1;
        chk("midrst_valid", ov[0], 0);
        rst = 1'b0;
        iv[0] = 1'b0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ov[0]) nv++;
        end
        chk("midrst_none", nv, 0);

        for (int i = 0; i < N; i++) acc[i] = 0;
        cyc = 0;
        while ((acc[0] < 2000 || acc[1] < 2000 || acc[2] < 2000 ||
                acc[3] < 2000) && cyc < 20000) begin
            for (int i = 0; i < N; i++) begin
                ordy[i] = ($urandom_range(0, 3) != 0);
                iv[i] = (acc[i] < 2000) && ($urandom_range(0, 4) != 0);
                xv[i] = rnd();
                yv[i] = ($urandom_range(0, 7) == 0) ? xv[i] : rnd();
                sb[i] = 1'($urandom_range(0, 1));
                it[i] = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("sweep_in_budget", (cyc < 20000), 1);
        iv = '0;
        ordy = '1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("drain%0d", i), cnt[i], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_pipe_mc.md
# addsub_pipe_mc

Parametrised, pipelined multi-limb adder/subtractor for Fp-width operands with a valid/ready handshake, per-operation add/sub select, a carry/borrow flag and a sideband tag. Operands are split into LIMBS equal limbs. Limb sums are computed in one stage, then merged pairwise in a log-depth carry tree, so long carry chains are broken across cycles. It replaces fixed-latency adder and subtractor instances in the field-arithmetic datapath wherever the consumer can stall.

## Interface
Parameters:
- WIDTH, 272: operand width. Must be divisible by LIMBS.
- LIMBS, 4: number of limbs. Must be a power of two, 1..16. Limb width LW = WIDTH/LIMBS.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk, in, 1: single clock. All state changes on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: an operation is presented on X, Y, sub, in_tag.
- in_ready, out, 1: the block accepts the operation this cycle.
- X, in, WIDTH: first operand, unsigned.
- Y, in, WIDTH: second operand, unsigned.
- sub, in, 1: 0 computes X+Y; 1 computes X−Y, implemented as X + ~Y + 1.
- in_tag, in, TAG_W: opaque tag returned unchanged with the result.
- out_valid, out, 1: Z, carry and out_tag hold a valid result.
- out_ready, in, 1: the consumer accepts the result this cycle.
- Z, out, WIDTH: the sum or difference, mod 2^WIDTH.
- carry, out, 1: for add, the carry-out. For sub, 1 means no borrow (X ≥ Y) and 0 means borrow (X < Y).
- out_tag, out, TAG_W: tag of the operation currently on Z.

## Operation
- Pipeline depth L = 1 + log2(LIMBS). The stages are S0..S(L−1), and S(L−1) drives the outputs.
- Stage S0:
  - Form Y' = sub ? ~Y : Y.
  - For each limb i, register {c_i, s_i} = X_i + Y'_i + (i==0 ? sub : 0), which is LW+1 bits.
- Stage Sk, for k ≥ 1:
  - Merge adjacent groups of 2^(k−1) limbs. Each merged group is {hi + lo.carry, lo.sum}.
  - The carry of the merged group is the carry-out of the hi addition.
  - Group width doubles each stage. The final stage holds one group of WIDTH bits plus 1 carry bit, which drives {carry, Z}.
- When LIMBS = 1, the block is a single registered stage: {carry, Z} = X + Y' + sub.
- sub and in_tag travel with their stage through the pipeline.
- Each stage has its own valid bit. The output stage valid bit is out_valid.
- Flow control is a global stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is combinational.
  - When stall is 1, every stage register (data, tag, valid) holds its value.
  - When stall is 0, all stages advance. S0 valid loads in_valid & in_ready.
- Bubbles advance like operations: an invalid stage still shifts. There is no bubble compression.
- Data registers of invalid stages are don't-care internally. The output registers update only on an advance.
- Results leave in issue order. There is no reordering and no loss.

## Timing
- Reset, whenever rst=1 at a clock edge:
  - All stage valid bits clear.
  - Z = 0, carry = 0, out_tag = 0, out_valid = 0.
  - in_ready is therefore 1 in the cycle after reset.
- Reset takes priority over acceptance and advance. An operation presented with rst=1 is dropped.
- Reset mid-operation drops all in-flight operations. No partial result is emitted.
- Latency: an operation accepted at edge T appears with out_valid=1 after edge T+L−1, i.e. visible in cycle T+L−1. This assumes no stall.
  - LIMBS=4: L=3.
  - LIMBS=8: L=4.
  - LIMBS=1: L=1.
- Throughput: one operation per cycle while out_ready=1.
- Stall behaviour:
  - While stall=1, Z, carry and out_tag are stable and in_ready=0.
  - If out_valid=1 and out_ready=1 in the same cycle, the result is consumed and a new input may be accepted in that same cycle.
- out_valid=0 with out_ready=0 does not stall the pipeline. Bubbles never block.
- Wrap-around: Z is always mod 2^WIDTH, with the overflow reported only in carry.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and X=Y=1.
  - Required: out_valid=0, Z=0, carry=0, out_tag=0 throughout.
  - Required: in_ready=1 in the first cycle after rst falls.
  - Required: no result ever emerges for the dropped input.
- Full carry chain (WIDTH=272, LIMBS=4): X = 2^272−1, Y = 1, sub = 0, tag = 5.
  - Required: exactly 3 cycles later, Z = 0, carry = 1, out_tag = 5.
  - Then X = 2^136−1, Y = 1: Z = 2^136, carry = 0.
- Subtract:
  - X = 0, Y = 1, sub = 1: Z = 2^272−1, carry = 0.
  - X = 5, Y = 5, sub = 1: Z = 0, carry = 1.
  - X = 2^200, Y = 1, sub = 1: Z = 2^200−1, carry = 1.
- Streaming: issue 8 back-to-back operations with tags 0..7, mixing add and sub, with out_ready=1.
  - Required: 8 consecutive out_valid cycles, tags in order 0..7, every result matching the golden model.
- Backpressure:
  - Drive out_ready=0 for 4 cycles starting when the first result becomes valid.
  - Required: in_ready=0 during that window; Z, carry and out_tag held constant; in_valid ignored during the window.
  - Required: after release, the remaining results arrive in order with no loss and no duplicates.
  - Also assert rst mid-stream: pipeline empties and out_valid=0 on the next cycle.
- Parameter sweep: LIMBS=1 (L=1), LIMBS=8 with WIDTH=256 (L=4), and LIMBS=16 with WIDTH=272.
  - Stimulus: 2000 random operations each, with random out_ready.
  - Required: zero mismatches against the (X ± Y, carry) model.
